// File: rtl/prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs31_checker
// Description : Self-synchronising PRBS31 (x^31 + x^28 + 1) receive checker.
//               Locks to the incoming sequence, flags errored words and bits
//               while locked, and keeps a saturating 32-bit error count.
//
// Ports       : clk             - sole clock, rising edge
//               rst             - synchronous active-high reset
//               data_in         - received word, MSB is earliest in time
//               data_in_valid   - word accepted on this edge when high
//               err_count_clear - synchronous clear of err_count (wins)
//               locked          - high while in LOCKED
//               err_word        - pulse: last accepted word had an error
//               err_bits        - mismatch mask of last accepted word
//               err_count       - saturating error count
//
// Macro       : PRBS31_CHECKER_BIT_COUNT_EN - when defined, err_count counts
//               errored bits instead of errored words.
//
// Revision    : 1.0 - initial release
// ============================================================================
module prbs31_checker #(
    parameter int DATA_WIDTH   = 8,
    parameter int LOCK_COUNT   = 16,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    input  logic                  err_count_clear,
    output logic                  locked,
    output logic                  err_word,
    output logic [DATA_WIDTH-1:0] err_bits,
    output logic [31:0]           err_count
);

    localparam logic [0:0] c_ST_HUNT          = 1'b0;
    localparam logic [0:0] c_ST_LOCKED        = 1'b1;
    localparam logic [7:0] c_LOCK_LAST_RUN    = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] c_UNLOCK_LAST_RUN  = 8'(UNLOCK_COUNT - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [30:0]           r_hist;
    logic [30:0]           r_ref;
    logic [7:0]            r_run;
    logic [7:0]            w_run_nxt;
    logic [30:0]           w_ref_nxt;
    logic                  r_err_word;
    logic [DATA_WIDTH-1:0] r_err_bits;
    logic [31:0]           r_err_count;

    logic [30:0]           w_seed;
    logic [30:0]           w_pred_state;
    logic [30:0]           w_hist_nxt;
    logic [DATA_WIDTH-1:0] w_pred;
    logic [DATA_WIDTH-1:0] w_mismatch;
    logic                  w_match;
    logic [DATA_WIDTH-1:0] w_err_bits_nxt;
    logic [32:0]           w_inc;
    logic [32:0]           w_sum;
    logic [31:0]           w_cnt_nxt;

    // Serial prediction unrolled across the word: each predicted bit is
    // pushed into the working state so later bits of the same word see it.
    // The post-word state doubles as the advanced reference while locked.
    always_comb begin : p_predict
        w_seed       = (r_state == c_ST_LOCKED) ? r_ref : r_hist;
        w_pred       = '0;
        w_pred_state = w_seed;
        w_hist_nxt   = r_hist;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            w_pred[i]    = w_pred_state[30] ^ w_pred_state[27];
            w_pred_state = {w_pred_state[29:0], w_pred[i]};
            w_hist_nxt   = {w_hist_nxt[29:0], data_in[i]};
        end
    end

    assign w_mismatch = data_in ^ w_pred;
    // An all-zero history is the degenerate LFSR state and predicts zeros;
    // it must never be taken as evidence of lock.
    assign w_match    = (w_mismatch == '0) && (r_hist != '0);

    always_comb begin : p_next_state
        w_state_nxt    = r_state;
        w_run_nxt      = r_run;
        w_ref_nxt      = r_ref;
        w_err_bits_nxt = '0;
        if (data_in_valid) begin
            case (r_state)
                c_ST_HUNT: begin
                    if (w_match) begin
                        if (r_run == c_LOCK_LAST_RUN) begin
                            w_state_nxt = c_ST_LOCKED;
                            w_run_nxt   = '0;
                            // Post-word history equals the predicted state here.
                            w_ref_nxt   = w_hist_nxt;
                        end else begin
                            w_run_nxt = r_run + 8'd1;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                c_ST_LOCKED: begin
                    // Reference free-runs on its own prediction so received
                    // errors cannot corrupt it.
                    w_ref_nxt      = w_pred_state;
                    w_err_bits_nxt = w_mismatch;
                    if (w_mismatch != '0) begin
                        if (r_run == c_UNLOCK_LAST_RUN) begin
                            w_state_nxt = c_ST_HUNT;
                            w_run_nxt   = '0;
                        end else begin
                            w_run_nxt = r_run + 8'd1;
                        end
                    end else begin
                        w_run_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_HUNT;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

`ifdef PRBS31_CHECKER_BIT_COUNT_EN
    logic [6:0] w_pop;

    always_comb begin : p_popcount
        w_pop = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_pop = w_pop + 7'(w_err_bits_nxt[i]);
        end
        w_inc = {26'd0, w_pop};
    end
`else
    // err_bits_nxt is already zero outside LOCKED or without valid.
    assign w_inc = {32'd0, |w_err_bits_nxt};
`endif

    always_comb begin : p_err_count
        w_sum     = {1'b0, r_err_count} + w_inc;
        w_cnt_nxt = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
        if (err_count_clear) begin
            w_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_HUNT;
            r_hist      <= '0;
            r_ref       <= '0;
            r_run       <= '0;
            r_err_word  <= 1'b0;
            r_err_bits  <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_ref       <= w_ref_nxt;
            if (data_in_valid) begin
                r_hist <= w_hist_nxt;
            end
            r_err_word  <= |w_err_bits_nxt;
            r_err_bits  <= w_err_bits_nxt;
            r_err_count <= w_cnt_nxt;
        end
    end

    assign locked    = (r_state == c_ST_LOCKED);
    assign err_word  = r_err_word;
    assign err_bits  = r_err_bits;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_prbs31_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs31_checker
// Description : Directed self-checking bench for prbs31_checker (8-bit words,
//               LOCK_COUNT 16, UNLOCK_COUNT 4). Stimulus comes from a local
//               PRBS31 generator seeded with all ones.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs31_checker;

    localparam int DW = 8;
`ifdef PRBS31_CHECKER_BIT_COUNT_EN
    localparam logic [31:0] c_EXP_BURST = 32'd32;
`else
    localparam logic [31:0] c_EXP_BURST = 32'd4;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          data_in_valid;
    logic          err_count_clear;
    logic          locked;
    logic          err_word;
    logic [DW-1:0] err_bits;
    logic [31:0]   err_count;

    logic [30:0]   gen_state;
    logic [DW-1:0] w;
    int            n_checks = 0;
    int            n_errors = 0;

    prbs31_checker #(
        .DATA_WIDTH   (DW),
        .LOCK_COUNT   (16),
        .UNLOCK_COUNT (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_in_valid   (data_in_valid),
        .err_count_clear (err_count_clear),
        .locked          (locked),
        .err_word        (err_word),
        .err_bits        (err_bits),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Generator: newest bit in gen_state[0], word MSB first.
    task automatic next_word(output logic [DW-1:0] word);
        logic b;
        for (int i = DW - 1; i >= 0; i--) begin
            b         = gen_state[30] ^ gen_state[27];
            gen_state = {gen_state[29:0], b};
            word[i]   = b;
        end
    endtask

    // One clock: inputs set at negedge, outputs sampled 1 ns after posedge.
    task automatic drive(input logic [DW-1:0] d, input logic v, input logic c);
        @(negedge clk);
        data_in         = d;
        data_in_valid   = v;
        err_count_clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_good(input int n);
        logic [DW-1:0] gw;
        for (int i = 0; i < n; i++) begin
            next_word(gw);
            drive(gw, 1'b1, 1'b0);
        end
    endtask

    // Reset with a valid, errored-looking word present to show rst wins.
    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        data_in         = 8'hFF;
        data_in_valid   = 1'b1;
        err_count_clear = 1'b0;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        data_in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        data_in         = '0;
        data_in_valid   = 1'b0;
        err_count_clear = 1'b0;
        do_reset();
        do_reset();
        check("rst_locked",    {31'd0, locked},   32'd0);
        check("rst_err_word",  {31'd0, err_word}, 32'd0);
        check("rst_err_bits",  {24'd0, err_bits}, 32'd0);
        check("rst_err_count", err_count,         32'd0);

        // Lock: words 1..4 see H == 0, words 5..20 are the 16 matches.
        gen_state = '1;
        send_good(19);
        check("lock_pre",   {31'd0, locked},   32'd0);
        send_good(1);
        check("lock_rise",  {31'd0, locked},   32'd1);
        check("lock_noerr", {31'd0, err_word}, 32'd0);
        check("lock_count", err_count,         32'd0);

        // Single-bit error on bit 3.
        next_word(w);
        drive(w ^ 8'h08, 1'b1, 1'b0);
        check("sbe_word",   {31'd0, err_word}, 32'd1);
        check("sbe_bits",   {24'd0, err_bits}, 32'h08);
        check("sbe_count",  err_count,         32'd1);
        check("sbe_locked", {31'd0, locked},   32'd1);
        send_good(1);
        check("sbe_next_word",   {31'd0, err_word}, 32'd0);
        check("sbe_next_bits",   {24'd0, err_bits}, 32'd0);
        check("sbe_next_locked", {31'd0, locked},   32'd1);
        check("sbe_next_count",  err_count,         32'd1);

        // Clear alongside a clean word.
        next_word(w);
        drive(w, 1'b1, 1'b1);
        check("clear_clean", err_count, 32'd0);

        // Burst of four inverted words forces unlock on the fourth.
        for (int i = 0; i < 4; i++) begin
            next_word(w);
            drive(~w, 1'b1, 1'b0);
            if (i == 2) check("burst3_locked", {31'd0, locked}, 32'd1);
        end
        check("burst_unlock", {31'd0, locked},   32'd0);
        check("burst_word",   {31'd0, err_word}, 32'd1);
        check("burst_bits",   {24'd0, err_bits}, 32'hFF);
        check("burst_count",  err_count,         c_EXP_BURST);

        // Relock. Inverted history still predicts correctly while both taps
        // land in the inverted span; clean bits 28..30 (4th clean word) see
        // one inverted tap and break the run, so the 16 matches are clean
        // words 5..20.
        send_good(19);
        check("relock_pre",  {31'd0, locked}, 32'd0);
        send_good(1);
        check("relock_rise", {31'd0, locked}, 32'd1);

        // Valid gaps: only accepted words count; idle garbage is ignored.
        do_reset();
        gen_state = '1;
        for (int i = 0; i < 20; i++) begin
            next_word(w);
            drive(w, 1'b1, 1'b0);
            if (i == 18) check("gap_pre",  {31'd0, locked}, 32'd0);
            if (i == 19) check("gap_rise", {31'd0, locked}, 32'd1);
            drive(8'hA5, 1'b0, 1'b0);
            if (i == 1)  check("gap_idle_word", {31'd0, err_word}, 32'd0);
        end
        check("gap_idle_locked", {31'd0, locked}, 32'd1);

        next_word(w);
        drive(w ^ 8'h01, 1'b1, 1'b0);
        check("gap_err_bits", {24'd0, err_bits}, 32'h01);
        drive(8'h00, 1'b0, 1'b0);
        check("gap_idle_after_err_word", {31'd0, err_word}, 32'd0);
        check("gap_idle_after_err_bits", {24'd0, err_bits}, 32'd0);
        send_good(1);
        check("gap_resume_clean", {31'd0, err_word}, 32'd0);
        check("gap_count",        err_count,         32'd1);

        // Saturation: preload just below the ceiling.
        force dut.r_err_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_err_count;
        next_word(w);
        drive(w ^ 8'h08, 1'b1, 1'b0);
        check("sat_reach", err_count, 32'hFFFF_FFFF);
        send_good(1);
        next_word(w);
        drive(w ^ 8'h08, 1'b1, 1'b0);
        check("sat_hold", err_count, 32'hFFFF_FFFF);
        next_word(w);
        drive(w ^ 8'h08, 1'b1, 1'b1);
        check("clr_wins",      err_count,         32'd0);
        check("clr_err_word",  {31'd0, err_word}, 32'd1);
        check("clr_locked",    {31'd0, locked},   32'd1);
        send_good(1);

        // Reset mid-operation while locked with a nonzero count.
        next_word(w);
        drive(w ^ 8'h08, 1'b1, 1'b0);
        check("pre_rst_count", err_count, 32'd1);
        do_reset();
        check("mid_rst_locked", {31'd0, locked},   32'd0);
        check("mid_rst_count",  err_count,         32'd0);
        check("mid_rst_bits",   {24'd0, err_bits}, 32'd0);
        check("mid_rst_word",   {31'd0, err_word}, 32'd0);
        gen_state = '1;
        send_good(19);
        check("rst_relock_pre",  {31'd0, locked}, 32'd0);
        send_good(1);
        check("rst_relock_rise", {31'd0, locked}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
